// File: rtl/codec_cfg_sequencer.sv
// Purpose: boots an audio codec over a single I2C write engine, then shares that engine with host register writes.
// Latency: first GO rises PWRUP_CYCLES+2 clk after start; one word per GO/END handshake, GAP_CYCLES idle between words.
// Backpressure: host wr_req is held pending until the first DONE cycle; wr_gnt is a one-cycle grant pulse.
//
// Ports:
//   clk, reset (async, active-low)   system clock and reset
//   start                            begins boot configuration (honoured in IDLE or ERROR only)
//   I2C_CLOCK                        clk divided by 2*CLK_DIV, 50% duty
//   i2c_DATA, GO, END, ack           word / request / status / acknowledge to the I2C engine
//   wr_req, wr_data, wr_gnt          host runtime write request, word and grant
//   busy, cfg_done, cfg_error        status (cfg_error is sticky until reset or start)

module codec_cfg_sequencer #(
    parameter int unsigned CLK_DIV        = 100,
    parameter int unsigned PWRUP_CYCLES   = 1000,
    parameter int unsigned GAP_CYCLES     = 64,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        I2C_CLOCK,
    output logic [15:0] i2c_DATA,
    output logic        GO,
    input  logic        END,
    input  logic        ack,
    input  logic        wr_req,
    input  logic [15:0] wr_data,
    output logic        wr_gnt,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_error
);

    localparam int unsigned CNT_MAX_A = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned DIV_W     = $clog2(CLK_DIV);
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRY + 2);
    localparam logic [3:0]  LAST_IDX  = 4'd10;

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_LOAD, S_SEND, S_BUSYW, S_CHECK, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t               state_q, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [DIV_W-1:0]     div_cnt;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [3:0]           index;
    logic [15:0]          host_word;
    logic                 src_host;
    logic                 retry_pend;
    logic                 ack_q;
    logic                 start_ok;
    logic                 hit_pwrup, hit_gap, hit_to, retry_ok, host_take;

    function automatic logic [15:0] boot_word(input logic [3:0] idx);
        case (idx)
            4'd0:    boot_word = 16'h1E00;  // codec reset
            4'd1:    boot_word = 16'h0017;
            4'd2:    boot_word = 16'h0217;
            4'd3:    boot_word = 16'h0479;
            4'd4:    boot_word = 16'h0679;
            4'd5:    boot_word = 16'h0812;
            4'd6:    boot_word = 16'h0A00;
            4'd7:    boot_word = 16'h0C00;
            4'd8:    boot_word = 16'h0E42;
            4'd9:    boot_word = 16'h1000;
            4'd10:   boot_word = 16'h1201;  // activate
            default: boot_word = 16'h0000;
        endcase
    endfunction

    assign start_ok  = start && (state_q == S_IDLE || state_q == S_ERROR);
    assign hit_pwrup = (cnt == CNT_W'(PWRUP_CYCLES - 1));
    assign hit_gap   = (cnt == CNT_W'(GAP_CYCLES - 1));
    assign hit_to    = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign retry_ok  = (retry_cnt < RETRY_W'(MAX_RETRY));
    assign host_take = (state_q == S_DONE) && wr_req;

    // I2C_CLOCK divider, free-running from reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt   <= '0;
            I2C_CLOCK <= 1'b0;
        end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt   <= '0;
            I2C_CLOCK <= ~I2C_CLOCK;
        end else begin
            div_cnt   <= div_cnt + DIV_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_nxt = S_PWRUP;
            S_PWRUP: if (hit_pwrup) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SEND;
            S_SEND: begin
                if (hit_to)    state_nxt = S_CHECK;
                else if (!END) state_nxt = S_BUSYW;
            end
            // END wins over a simultaneous timeout: the transfer did finish.
            S_BUSYW: if (END || hit_to) state_nxt = S_CHECK;
            S_CHECK: begin
                if (ack_q) begin
                    if (src_host || index == LAST_IDX) state_nxt = S_DONE;
                    else                               state_nxt = S_GAP;
                end else if (retry_ok) begin
                    state_nxt = S_GAP;
                end else begin
                    state_nxt = src_host ? S_DONE : S_ERROR;
                end
            end
            S_GAP:   if (hit_gap) state_nxt = retry_pend ? S_SEND : S_LOAD;
            S_DONE:  if (wr_req) state_nxt = S_LOAD;
            S_ERROR: if (start_ok) state_nxt = S_PWRUP;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs; GO drops asynchronously with reset because it decodes the state register.
    always_comb begin
        GO       = (state_q == S_SEND) || (state_q == S_BUSYW);
        cfg_done = (state_q == S_DONE);
        busy     = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    end

    // Datapath: counters, word register, retry bookkeeping, host latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            retry_cnt  <= '0;
            index      <= '0;
            host_word  <= '0;
            src_host   <= 1'b0;
            retry_pend <= 1'b0;
            ack_q      <= 1'b0;
            i2c_DATA   <= '0;
            wr_gnt     <= 1'b0;
            cfg_error  <= 1'b0;
        end else begin
            // One shared counter; it restarts on every state entry except SEND->BUSYW,
            // so the timeout spans the whole attempt.
            if (state_nxt != state_q && !(state_q == S_SEND && state_nxt == S_BUSYW))
                cnt <= '0;
            else if (state_q == S_PWRUP || state_q == S_GAP || state_q == S_SEND || state_q == S_BUSYW)
                cnt <= cnt + CNT_W'(1);
            else
                cnt <= '0;

            if (state_q == S_BUSYW && END)
                ack_q <= ack;
            else if ((state_q == S_SEND || state_q == S_BUSYW) && hit_to)
                ack_q <= 1'b0;

            if (start_ok) begin
                index     <= '0;
                src_host  <= 1'b0;
                cfg_error <= 1'b0;
            end

            if (state_q == S_LOAD) begin
                i2c_DATA  <= src_host ? host_word : boot_word(index);
                retry_cnt <= '0;
            end

            if (state_q == S_CHECK) begin
                retry_pend <= !ack_q;
                if (ack_q) begin
                    if (!src_host) index <= index + 4'd1;
                end else if (retry_ok) begin
                    retry_cnt <= retry_cnt + RETRY_W'(1);
                end else begin
                    cfg_error <= 1'b1;
                end
            end

            // Grant is registered: it pulses in the cycle after the first DONE cycle.
            wr_gnt <= host_take;
            if (host_take) begin
                host_word <= wr_data;
                src_host  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench for codec_cfg_sequencer with a behavioural I2C engine model.
module tb_codec_cfg_sequencer;

    localparam int CLK_DIV = 4;
    localparam int PWRUP   = 20;
    localparam int GAP     = 8;
    localparam int RETRY   = 3;
    localparam int TO      = 50;
    localparam logic [15:0] BOOT_TBL [0:10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                                                16'h0812, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1000, 16'h1201};

    logic        clk = 1'b0;
    logic        reset, start, END, ack, wr_req;
    logic [15:0] wr_data;
    logic        I2C_CLOCK, GO, wr_gnt, busy, cfg_done, cfg_error;
    logic [15:0] i2c_DATA;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // engine controls
    logic [15:0] nack_word = 16'hFFFF;
    int          nack_left = 0;
    bit          eng_stuck = 0;

    // monitor log
    int          go_count = 0, gnt_count = 0, gnt_cyc = -1, done_rise_cyc = -1, start_cyc = 0;
    logic [15:0] sent_q[$];
    int          go_rise_q[$], go_fall_q[$];
    bit          go_prev = 0, done_prev = 0;

    codec_cfg_sequencer #(
        .CLK_DIV(CLK_DIV), .PWRUP_CYCLES(PWRUP), .GAP_CYCLES(GAP),
        .MAX_RETRY(RETRY), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .I2C_CLOCK(I2C_CLOCK), .i2c_DATA(i2c_DATA),
        .GO(GO), .END(END), .ack(ack), .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .busy(busy), .cfg_done(cfg_done), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (GO && !go_prev) begin
            go_count++;
            sent_q.push_back(i2c_DATA);
            go_rise_q.push_back(cyc);
        end
        if (!GO && go_prev) go_fall_q.push_back(cyc);
        if (wr_gnt) begin
            gnt_count++;
            gnt_cyc = cyc;
        end
        if (cfg_done && !done_prev && done_rise_cyc < 0) done_rise_cyc = cyc;
        go_prev   = GO;
        done_prev = cfg_done;
    end

    // Engine model: pulls END low one negedge after seeing GO, finishes 3 cycles later.
    initial begin
        END = 1'b1;
        ack = 1'b0;
        forever begin
            @(negedge clk);
            if (GO === 1'b1 && !eng_stuck) begin
                END = 1'b0;
                repeat (3) @(negedge clk);
                if (i2c_DATA == nack_word && nack_left > 0) begin
                    ack = 1'b0;
                    nack_left--;
                end else begin
                    ack = 1'b1;
                end
                END = 1'b1;
                for (int k = 0; k < 20 && GO === 1'b1; k++) @(negedge clk);
            end
        end
    end

    task automatic clear_log();
        go_count = 0; gnt_count = 0; gnt_cyc = -1; done_rise_cyc = -1;
        sent_q.delete(); go_rise_q.delete(); go_fall_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; start = 1'b0; wr_req = 1'b0; wr_data = 16'h0;
        nack_word = 16'hFFFF; nack_left = 0; eng_stuck = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_log();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_settle(input int max_cyc, output bit ok);
        ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (cfg_done || (cfg_error && !busy)) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; wr_req = 1'b0; wr_data = 16'h0;
        repeat (3) @(negedge clk);
        checks++; if (GO !== 1'b0) begin errors++; $display("FAIL reset_go got %b want 0", GO); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (cfg_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", cfg_done); end
        checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", cfg_error); end
        checks++; if (wr_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", wr_gnt); end
        checks++; if (i2c_DATA !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", i2c_DATA); end
        checks++; if (I2C_CLOCK !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", I2C_CLOCK); end
    endtask

    task automatic test_divider();
        // reset released at a negedge; toggles land after 4, 8, 12 rising edges
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (I2C_CLOCK !== 1'b0) begin errors++; $display("FAIL div_e3 got %b want 0", I2C_CLOCK); end
        @(negedge clk);
        checks++; if (I2C_CLOCK !== 1'b1) begin errors++; $display("FAIL div_e4 got %b want 1", I2C_CLOCK); end
        repeat (3) @(negedge clk);
        checks++; if (I2C_CLOCK !== 1'b1) begin errors++; $display("FAIL div_e7 got %b want 1", I2C_CLOCK); end
        @(negedge clk);
        checks++; if (I2C_CLOCK !== 1'b0) begin errors++; $display("FAIL div_e8 got %b want 0", I2C_CLOCK); end
        repeat (4) @(negedge clk);
        checks++; if (I2C_CLOCK !== 1'b1) begin errors++; $display("FAIL div_e12 got %b want 1", I2C_CLOCK); end
    endtask

    task automatic test_boot();
        bit ok;
        logic [15:0] got;
        do_reset();
        pulse_start();
        wait_settle(1500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL boot_settle got timeout want done"); end
        checks++; if (go_count !== 11) begin errors++; $display("FAIL boot_go_count got %0d want 11", go_count); end
        for (int i = 0; i < 11; i++) begin
            got = (i < sent_q.size()) ? sent_q[i] : 16'hxxxx;
            checks++; if (got !== BOOT_TBL[i]) begin errors++; $display("FAIL boot_word[%0d] got %h want %h", i, got, BOOT_TBL[i]); end
        end
        checks++; if (go_rise_q.size() < 2 || go_rise_q[0] - start_cyc !== PWRUP + 2)
            begin errors++; $display("FAIL boot_latency got %0d want %0d", go_rise_q.size() > 0 ? go_rise_q[0] - start_cyc : -1, PWRUP + 2); end
        checks++; if (go_rise_q.size() < 2 || go_rise_q[1] - go_rise_q[0] !== 14)
            begin errors++; $display("FAIL boot_spacing got %0d want 14", go_rise_q.size() > 1 ? go_rise_q[1] - go_rise_q[0] : -1); end
        checks++; if (cfg_done !== 1'b1 || cfg_error !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL boot_status got done=%b err=%b busy=%b want 1 0 0", cfg_done, cfg_error, busy); end
    endtask

    task automatic test_nack_once();
        bit ok;
        do_reset();
        nack_word = 16'h0679; nack_left = 1;
        pulse_start();
        wait_settle(1500, ok);
        checks++; if (!ok || cfg_done !== 1'b1 || cfg_error !== 1'b0)
            begin errors++; $display("FAIL nack1_status got ok=%b done=%b err=%b want 1 1 0", ok, cfg_done, cfg_error); end
        checks++; if (go_count !== 12) begin errors++; $display("FAIL nack1_go_count got %0d want 12", go_count); end
        checks++; if (sent_q.size() < 6 || sent_q[4] !== 16'h0679 || sent_q[5] !== 16'h0679)
            begin errors++; $display("FAIL nack1_resend got %h %h want 0679 0679", sent_q.size() > 4 ? sent_q[4] : 16'hxxxx, sent_q.size() > 5 ? sent_q[5] : 16'hxxxx); end
        // 5 cycles of handshake+CHECK, then GAP cycles, then straight back to SEND
        checks++; if (go_rise_q.size() < 6 || go_rise_q[5] - go_rise_q[4] !== GAP + 5)
            begin errors++; $display("FAIL nack1_gap got %0d want %0d", go_rise_q.size() > 5 ? go_rise_q[5] - go_rise_q[4] : -1, GAP + 5); end
    endtask

    task automatic test_nack_exhaust();
        bit ok;
        do_reset();
        nack_word = 16'h0812; nack_left = 4;
        wr_data = 16'h1234; wr_req = 1'b1;
        pulse_start();
        wait_settle(1500, ok);
        repeat (30) @(negedge clk);
        checks++; if (!ok || cfg_error !== 1'b1 || cfg_done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL exh_status got ok=%b err=%b done=%b busy=%b want 1 1 0 0", ok, cfg_error, cfg_done, busy); end
        checks++; if (go_count !== 9) begin errors++; $display("FAIL exh_go_count got %0d want 9", go_count); end
        checks++; if (sent_q.size() < 9 || sent_q[8] !== 16'h0812)
            begin errors++; $display("FAIL exh_last_word got %h want 0812", sent_q.size() > 8 ? sent_q[8] : 16'hxxxx); end
        checks++; if (gnt_count !== 0) begin errors++; $display("FAIL exh_no_gnt got %0d want 0", gnt_count); end
        clear_log();
        pulse_start();
        checks++; if (busy !== 1'b1 || cfg_error !== 1'b0 || wr_gnt !== 1'b0)
            begin errors++; $display("FAIL exh_restart got busy=%b err=%b gnt=%b want 1 0 0", busy, cfg_error, wr_gnt); end
        wr_req = 1'b0;
        wait_settle(1500, ok);
        checks++; if (!ok || cfg_done !== 1'b1 || go_count !== 11 || sent_q.size() == 0 || sent_q[0] !== 16'h1E00)
            begin errors++; $display("FAIL exh_reboot got done=%b gos=%0d first=%h want 1 11 1e00", cfg_done, go_count, sent_q.size() > 0 ? sent_q[0] : 16'hxxxx); end
    endtask

    task automatic test_host_write();
        bit got_gnt = 0;
        do_reset();
        pulse_start();
        repeat (40) @(negedge clk);
        wr_data = 16'h0060; wr_req = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wr_gnt) begin
                wr_req = 1'b0;
                got_gnt = 1;
            end else if (got_gnt && cfg_done) begin
                break;
            end
        end
        checks++; if (!got_gnt || gnt_count !== 1) begin errors++; $display("FAIL host_gnt_count got %0d want 1", gnt_count); end
        checks++; if (gnt_cyc !== done_rise_cyc + 1) begin errors++; $display("FAIL host_gnt_time got %0d want %0d", gnt_cyc, done_rise_cyc + 1); end
        checks++; if (go_count !== 12 || sent_q.size() < 12 || sent_q[11] !== 16'h0060)
            begin errors++; $display("FAIL host_word got gos=%0d last=%h want 12 0060", go_count, sent_q.size() > 11 ? sent_q[11] : 16'hxxxx); end
        checks++; if (cfg_done !== 1'b1 || cfg_error !== 1'b0)
            begin errors++; $display("FAIL host_status got done=%b err=%b want 1 0", cfg_done, cfg_error); end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        eng_stuck = 1;
        pulse_start();
        wait_settle(1500, ok);
        checks++; if (!ok || cfg_error !== 1'b1 || cfg_done !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL to_status got ok=%b err=%b done=%b busy=%b want 1 1 0 0", ok, cfg_error, cfg_done, busy); end
        checks++; if (go_count !== RETRY + 1) begin errors++; $display("FAIL to_attempts got %0d want %0d", go_count, RETRY + 1); end
        checks++; if (go_fall_q.size() < 1 || go_fall_q[0] - go_rise_q[0] !== TO)
            begin errors++; $display("FAIL to_go_width got %0d want %0d", go_fall_q.size() > 0 ? go_fall_q[0] - go_rise_q[0] : -1, TO); end
        checks++; if (sent_q.size() < 4 || sent_q[3] !== 16'h1E00)
            begin errors++; $display("FAIL to_word got %h want 1e00", sent_q.size() > 3 ? sent_q[3] : 16'hxxxx); end
    endtask

    task automatic test_reset_midxfer();
        bit seen = 0;
        int gc;
        do_reset();
        pulse_start();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (GO === 1'b1 && END === 1'b0) begin
                seen = 1;
                break;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL rst_mid_reach got timeout want busyw"); end
        reset = 1'b0;
        #1;
        checks++; if (GO !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_async got go=%b busy=%b want 0 0", GO, busy); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        gc = go_count;
        repeat (100) @(negedge clk);
        checks++; if (go_count !== gc || GO !== 1'b0) begin errors++; $display("FAIL rst_mid_nogo got %0d want %0d", go_count, gc); end
        checks++; if (busy !== 1'b0 || cfg_done !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got busy=%b done=%b want 0 0", busy, cfg_done); end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_boot();
        test_nack_once();
        test_nack_exhaust();
        test_host_write();
        test_timeout();
        test_reset_midxfer();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
